// File: rtl/alu_seq.sv
// Registered ALU: logic/arithmetic ops finish in one clock, SLL/SRL shift
// one bit per clock. start/ready/done handshake toward the datapath controller.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_JR  = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [SHW-1:0]   count;
  logic [WIDTH-1:0] shreg;
  logic             dir_right;

  logic             load_result;
  logic             load_shift;
  logic [WIDTH-1:0] res_nx;
  logic             ill_nx;
  logic [WIDTH-1:0] shift_nx;

  // Single-cycle ops; returns {illegal, result}. Unknown opcodes yield 0.
  function automatic logic [WIDTH:0] alu_eval(input logic [3:0] f_op,
                                              input logic [WIDTH-1:0] f_a,
                                              input logic [WIDTH-1:0] f_b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [WIDTH:0]          r;
    sa = f_a;
    sb = f_b;
    r  = '0;
    case (f_op)
      OP_AND:  r[WIDTH-1:0] = f_a & f_b;
      OP_OR:   r[WIDTH-1:0] = f_a | f_b;
      OP_ADD:  r[WIDTH-1:0] = f_a + f_b;
      OP_SUB:  r[WIDTH-1:0] = f_a - f_b;
      OP_SLT:  r[WIDTH-1:0] = {{(WIDTH-1){1'b0}}, (sa < sb)};
      OP_JR:   r[WIDTH-1:0] = f_a;
      default: r[WIDTH]     = 1'b1;
    endcase
    return r;
  endfunction

  assign ready    = (state == IDLE);
  assign shift_nx = dir_right ? (shreg >> 1) : (shreg << 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    load_result = 1'b0;
    load_shift  = 1'b0;
    res_nx      = '0;
    ill_nx      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (op == OP_SLL || op == OP_SRL) begin
            if (shamt == '0) begin
              load_result = 1'b1;
              res_nx      = b;
            end else begin
              load_shift = 1'b1;
              state_nx   = SHIFT;
            end
          end else begin
            load_result      = 1'b1;
            {ill_nx, res_nx} = alu_eval(op, a, b);
          end
        end
      end
      SHIFT: begin
        // count==1 means this edge performs the last shift
        if (count == SHW'(1)) begin
          load_result = 1'b1;
          res_nx      = shift_nx;
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
      count     <= '0;
      shreg     <= '0;
      dir_right <= 1'b0;
    end else begin
      done <= load_result;
      if (load_result) begin
        result  <= res_nx;
        zero    <= (res_nx == '0);
        illegal <= ill_nx;
      end
      if (load_shift) begin
        shreg     <= b;
        count     <= shamt;
        dir_right <= (op == OP_SRL);
      end else if (state == SHIFT) begin
        shreg <= shift_nx;
        count <= count - SHW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a scoreboard queue holds expected completions,
// a negedge monitor pops and compares them whenever done is high.
module tb_alu_seq;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             z;
    logic             ill;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a, b;
  logic [SHW-1:0]   shamt;
  logic             ready, done, zero, illegal;
  logic [WIDTH-1:0] result;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .shamt(shamt), .ready(ready), .done(done), .result(result),
    .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Completion monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL spurious_done: observed done=1 expected no pending op");
      end
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_result",  result,          e.res);
        chk("sb_zero",    {31'b0, zero},    {31'b0, e.z});
        chk("sb_illegal", {31'b0, illegal}, {31'b0, e.ill});
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Drive a request at the current negedge and optionally expect a completion.
  task automatic issue(input logic [3:0] o, input logic [WIDTH-1:0] va,
                       input logic [WIDTH-1:0] vb, input logic [SHW-1:0] sh,
                       input bit push, input logic [WIDTH-1:0] er,
                       input logic ei);
    exp_t e;
    start = 1'b1; op = o; a = va; b = vb; shamt = sh;
    if (push) begin
      e.res = er; e.z = (er == '0); e.ill = ei;
      sb.push_back(e);
    end
  endtask

  initial begin
    int j;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; shamt = '0;
    step(); step();
    chk("rst_ready",   {31'b0, ready},   32'd1);
    chk("rst_done",    {31'b0, done},    32'd0);
    chk("rst_result",  result,           32'd0);
    chk("rst_zero",    {31'b0, zero},    32'd0);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);
    rst_n = 1'b1;
    step();

    // ADD then SUB back to back
    issue(4'b0010, 32'hFFFF_FFFF, 32'd1, '0, 1, 32'd0, 1'b0);
    step();
    issue(4'b0110, 32'd5, 32'd7, '0, 1, 32'hFFFF_FFFE, 1'b0);
    chk("add_done", {31'b0, done}, 32'd1);
    chk("add_ready", {31'b0, ready}, 32'd1);
    step();
    start = 1'b0;
    chk("sub_done", {31'b0, done}, 32'd1);
    step();
    chk("idle_done", {31'b0, done}, 32'd0);

    // SLT signed, three in a row
    issue(4'b0111, 32'hFFFF_FFFF, 32'd1, '0, 1, 32'd1, 1'b0);
    step();
    issue(4'b0111, 32'd1, 32'hFFFF_FFFF, '0, 1, 32'd0, 1'b0);
    step();
    issue(4'b0111, 32'd3, 32'd3, '0, 1, 32'd0, 1'b0);
    step();
    start = 1'b0;
    chk("slt3_done", {31'b0, done}, 32'd1);
    step();

    // SLL b=1 by 4 with a busy AND and a b change mid-shift
    issue(4'b0100, 32'd0, 32'd1, 5'd4, 1, 32'h10, 1'b0);
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("sll4_ready_low", {31'b0, ready}, 32'd0);
      chk("sll4_no_done",   {31'b0, done},  32'd0);
      if (i == 1) begin
        start = 1'b1; op = 4'b0000; a = 32'hFFFF; b = 32'hFFFF;
      end
      if (i == 2) start = 1'b0;
      step();
    end
    chk("sll4_done",  {31'b0, done},  32'd1);
    chk("sll4_ready", {31'b0, ready}, 32'd1);
    step();
    chk("sll4_single_done", {31'b0, done}, 32'd0);

    // SRL 0x80000000 by 31: latency measured in edges
    issue(4'b0101, 32'd0, 32'h8000_0000, 5'd31, 1, 32'd1, 1'b0);
    step();
    start = 1'b0;
    j = 0;
    while (done !== 1'b1 && j < 40) begin
      step();
      j++;
    end
    chk("srl31_latency", 32'(j), 32'd31);
    step();

    // SLL with shamt=0 completes in one cycle
    issue(4'b0100, 32'd0, 32'h1234, 5'd0, 1, 32'h1234, 1'b0);
    step();
    start = 1'b0;
    chk("sll0_done", {31'b0, done}, 32'd1);
    step();

    // Illegal, then JR, AND, OR
    issue(4'b1111, 32'h55, 32'h66, '0, 1, 32'd0, 1'b1);
    step();
    issue(4'b0011, 32'h0040_0020, 32'd9, '0, 1, 32'h0040_0020, 1'b0);
    step();
    issue(4'b0000, 32'hF0F0, 32'h0FF0, '0, 1, 32'h00F0, 1'b0);
    step();
    issue(4'b0001, 32'hF0F0, 32'h0FF0, '0, 1, 32'hFFF0, 1'b0);
    step();
    start = 1'b0;
    step();

    // Reset mid-shift takes effect immediately
    issue(4'b0100, 32'd0, 32'd1, 5'd20, 0, 32'd0, 1'b0);
    step();
    start = 1'b0;
    repeat (5) step();
    chk("midshift_busy", {31'b0, ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_ready",  {31'b0, ready}, 32'd1);
    chk("arst_done",   {31'b0, done},  32'd0);
    chk("arst_result", result,         32'd0);
    step();
    rst_n = 1'b1;
    step();
    issue(4'b0100, 32'd0, 32'd1, 5'd1, 1, 32'h2, 1'b0);
    step();
    start = 1'b0;
    chk("sll1_busy", {31'b0, ready}, 32'd0);
    step();
    chk("sll1_done", {31'b0, done}, 32'd1);
    repeat (3) step();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered ALU that consumes the 4-bit ALU opcode produced by the ALU control decoder and executes the operation on two 32-bit operands. Logic and arithmetic ops complete in one clock. Shifts run bit-serially, one position per clock. A start/ready/done handshake lets the datapath controller issue operations and detect completion.

## Interface
Parameters:
- WIDTH, 32, operand and result width
- SHW, 5, shift-amount width; must equal log2(WIDTH)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only while ready=1
- op  in  4  ALU opcode:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT
  - 0011 JR (pass A)
  - 0100 SLL
  - 0101 SRL
- a  in  WIDTH  operand A (rs)
- b  in  WIDTH  operand B (rt); this is the operand shifted by SLL/SRL
- shamt  in  SHW  shift amount, used by SLL/SRL only
- ready  out  1  block idle and accepting start
- done  out  1  one-cycle pulse; result/zero/illegal valid from this cycle
- result  out  WIDTH  registered result, held until next completion
- zero  out  1  registered, result==0
- illegal  out  1  registered, op not in table; updated with done

## Operation
- FSM has 2 states: IDLE (ready=1) and SHIFT (ready=0).
- IDLE, start=1, non-shift op:
  - Compute combinationally from a, b.
  - Register result, zero, illegal; pulse done.
  - Remain in IDLE.
- IDLE, start=1, SLL/SRL, shamt=0: result=b, done pulse, remain in IDLE.
- IDLE, start=1, SLL/SRL, shamt=k>0:
  - Capture b into the shift register, count=k, and the direction.
  - Go to SHIFT.
- SHIFT, each edge:
  - Shift one bit (SLL left, SRL right logical, zero fill); count decrements.
  - When count reaches 0: register result and zero, pulse done, return to IDLE.
- ADD and SUB wrap modulo 2^WIDTH; no overflow flag.
- SLT is signed two's-complement: result = {WIDTH-1 zeros, (a<b)}.
- JR: result=a.
- Illegal op: result=0, zero=1, illegal=1, done pulse, single-cycle.
- Operands and op are captured at start. Input changes during SHIFT have no effect.
- start while ready=0 is ignored; it is neither queued nor an error.
- illegal is cleared on the next legal completion.

## Timing
- Reset (asynchronous, immediate, including mid-shift):
  - Outputs: ready=1, done=0, result=0, zero=0, illegal=0.
  - Internal: state=IDLE, count=0, shift register=0.
  - Release takes effect at the next rising edge.
- Start accepted at edge N:
  - Non-shift op, or shift with shamt=0: done=1 and result valid in the cycle after edge N; ready stays 1.
  - Shift with shamt=k>0: ready=0 from edge N to edge N+k; done=1 and ready=1 after edge N+k. Latency is k cycles; the maximum, k=WIDTH-1, is 31 cycles.
- done is high for exactly one cycle per accepted start; otherwise done=0.
- Back-to-back:
  - start may be asserted in the same cycle done is high (ready=1), so non-shift ops sustain 1 op/cycle.
  - A new start accepted while done is high overwrites result at the next completion only.

## Test plan
- Reset mid-shift: start SLL, b=1, shamt=20; assert rst_n=0 after 5 cycles → immediately ready=1, done=0, result=0. Then SLL b=1, shamt=1 → result=0x2.
- Arithmetic, 1 op/cycle:
  - ADD a=0xFFFFFFFF, b=1 → result=0, zero=1.
  - SUB a=5, b=7 → 0xFFFFFFFE, zero=0.
  - Each done arrives one cycle after its start, with no gaps.
- SLT signed:
  - a=0xFFFFFFFF, b=1 → 1.
  - a=1, b=0xFFFFFFFF → 0, zero=1.
  - a=b=3 → 0.
- Shifts:
  - SLL b=1, shamt=4 at edge 0 → ready=0 for 4 cycles, done after edge 4, result=0x10.
  - SRL b=0x80000000, shamt=31 → 0x1 after 31 cycles.
  - SLL shamt=0, b=0x1234 → 0x1234 in one cycle.
- Busy handling: start AND while SHIFT is active → ignored; single done, shift result unchanged. Changing b mid-shift does not alter the result.
- Illegal and JR:
  - op=1111 → done, illegal=1, result=0, zero=1.
  - JR a=0x00400020 next → result=0x00400020, illegal=0.
  - AND 0xF0F0 & 0x0FF0 → 0x00F0.
  - OR → 0xFFF0.
